// File: rtl/sha256_round_ctrl.sv
// Round sequencer for one SHA-256 block compression: walks IDLE/INIT/LOAD/ROUND/FINAL/DONE,
// drives the round index and datapath strobes, and counts finished blocks of a message.
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             first_block,
    output logic             start_ready,
    input  logic             abort,
    input  logic             round_stall,
    output logic [5:0]       round,
    output logic             round_en,
    output logic             w_sel,
    output logic             h_init,
    output logic             load_work,
    output logic             final_add,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [CNT_W-1:0] blk_count
);

    if (NUM_ROUNDS != 64) begin : g_rounds_chk
        $error("sha256_round_ctrl: NUM_ROUNDS must be 64");
    end

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [5:0]       round_q, round_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;

    // start_ready is a flop mirroring state==IDLE, so the accept term stays register-driven.
    always_comb begin
        state_nx = state;
        round_nx = round_q;
        cnt_nx   = cnt_q;
        round_en = (state == S_ROUND) && !round_stall;
        if (abort && (state != S_IDLE)) begin
            state_nx = S_IDLE;
            round_nx = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && start_ready) begin
                        state_nx = first_block ? S_INIT : S_LOAD;
                        if (first_block) cnt_nx = '0;
                    end
                end
                S_INIT:  state_nx = S_LOAD;
                S_LOAD:  state_nx = S_ROUND;
                S_ROUND: begin
                    if (round_en) begin
                        if (round_q == LAST_ROUND) begin
                            state_nx = S_FINAL;
                            round_nx = '0;
                        end else begin
                            round_nx = round_q + 6'd1;
                        end
                    end
                end
                S_FINAL: state_nx = S_DONE;
                S_DONE: begin
                    if (done_ready) begin
                        state_nx = S_IDLE;
                        cnt_nx   = cnt_q + CNT_W'(1);
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            round_q     <= '0;
            cnt_q       <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            h_init      <= 1'b0;
            load_work   <= 1'b0;
            final_add   <= 1'b0;
            done_valid  <= 1'b0;
        end else begin
            state       <= state_nx;
            round_q     <= round_nx;
            cnt_q       <= cnt_nx;
            start_ready <= (state_nx == S_IDLE);
            busy        <= (state_nx != S_IDLE);
            h_init      <= (state_nx == S_INIT);
            load_work   <= (state_nx == S_LOAD);
            final_add   <= (state_nx == S_FINAL);
            done_valid  <= (state_nx == S_DONE);
        end
    end

    assign round     = round_q;
    assign w_sel     = (state == S_ROUND) && (round_q >= 6'd16);
    assign blk_count = cnt_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench: the driver predicts each block's done time, strobe counts and blk_count;
// a negedge monitor checks rounds/w_sel every cycle and pops predictions when done_valid rises.
module tb_sha256_round_ctrl;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, start, first_block, abort, round_stall, done_ready;
    logic             start_ready, round_en, w_sel, h_init, load_work, final_add, busy, done_valid;
    logic [5:0]       round;
    logic [CNT_W-1:0] blk_count;

    sha256_round_ctrl #(.NUM_ROUNDS(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .first_block(first_block),
        .start_ready(start_ready), .abort(abort), .round_stall(round_stall),
        .round(round), .round_en(round_en), .w_sel(w_sel), .h_init(h_init),
        .load_work(load_work), .final_add(final_add), .busy(busy),
        .done_valid(done_valid), .done_ready(done_ready), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int blk;
        int hinit;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;
    int   model_cnt = 0;
    int   plan[64];
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_idle(input string tag, input int exp_cnt);
        chk({tag, " start_ready"}, int'(start_ready), 1);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " round"}, int'(round), 0);
        chk({tag, " strobes"}, int'({round_en, w_sel, h_init, load_work, final_add, done_valid}), 0);
        chk({tag, " blk_count"}, int'(blk_count), exp_cnt);
    endtask

    // Monitor: round sequencing per cycle, and the per-block prediction on each done rise.
    int rcnt, nh, nl, nf, cur_blk;
    bit dv_q = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!busy) begin
                rcnt = 0; nh = 0; nl = 0; nf = 0;
            end
            if (h_init) nh++;
            if (load_work) nl++;
            if (final_add) nf++;
            if (round_en) begin
                chk("round seq", int'(round), rcnt);
                chk("w_sel", int'(w_sel), (rcnt >= 16) ? 1 : 0);
                rcnt++;
            end else if (busy && rcnt < 64) begin
                chk("round hold", int'(round), rcnt);
            end else begin
                chk("round idle", int'(round), 0);
            end
            if (done_valid && !dv_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done latency", cyc, e.due);
                    chk("blk_count at done", int'(blk_count), e.blk);
                    chk("h_init pulses", nh, e.hinit);
                    chk("load_work pulses", nl, 1);
                    chk("final_add pulses", nf, 1);
                    chk("rounds run", rcnt, 64);
                    cur_blk = e.blk;
                end
            end else if (done_valid) begin
                chk("blk_count hold", int'(blk_count), cur_blk);
            end
            dv_q = done_valid;
        end
    end

    // abort_at/rst_at: round index at which to fire (-1 none); abort_at==64 aborts in DONE.
    task automatic run_block(input bit first, input int hold, input int abort_at, input int rst_at);
        int   a, tot, t;
        exp_t e;
        t = 0;
        while (!start_ready && t < 100) begin @(posedge clk); #1; t++; end
        start = 1'b1; first_block = first;
        @(posedge clk); #1;
        a = cyc;
        start = 1'b0; first_block = 1'($urandom);
        if (first) model_cnt = 0;
        tot = 0;
        for (int r = 0; r < 64; r++) tot += plan[r];
        e.due = a + (first ? 67 : 66) + tot;
        e.blk = model_cnt;
        e.hinit = first ? 1 : 0;
        sb.push_back(e);
        repeat (first ? 2 : 1) begin round_stall = 1'($urandom); @(posedge clk); #1; end
        for (int r = 0; r < 64; r++) begin
            for (int s = 0; s < plan[r]; s++) begin round_stall = 1'b1; @(posedge clk); #1; end
            round_stall = 1'b0;
            if (r == abort_at) abort = 1'b1;
            if (r == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            if (abort || rst) begin
                if (rst) model_cnt = 0;
                abort = 1'b0; rst = 1'b0;
                chk_idle((r == rst_at) ? "after rst" : "after abort", model_cnt);
                void'(sb.pop_back());
                return;
            end
        end
        t = 0;
        round_stall = 1'($urandom);
        while (!done_valid && t < 20) begin
            @(posedge clk); #1; round_stall = 1'($urandom); t++;
        end
        round_stall = 1'b0;
        if (!done_valid) begin
            chk("done timeout", 0, 1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            start = 1'($urandom); first_block = 1'($urandom);
            @(posedge clk); #1;
        end
        if (abort_at == 64) begin
            abort = 1'b1; start = 1'b0;
            @(posedge clk); #1;
            abort = 1'b0;
            chk_idle("abort in done", model_cnt);
            return;
        end
        done_ready = 1'b1; start = 1'($urandom); first_block = 1'($urandom);
        @(posedge clk); #1;
        done_ready = 1'b0; start = 1'b0;
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
        chk_idle("after handshake", model_cnt);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; first_block = 1'b0; abort = 1'b0;
        round_stall = 1'b0; done_ready = 1'b0;
        foreach (plan[i]) plan[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset", 0);
        rst = 1'b0;
        mon_en = 1'b1;

        run_block(1'b1, 0, -1, -1);
        run_block(1'b0, 0, -1, -1);
        plan[20] = 5; plan[63] = 2;
        run_block(1'b1, 0, -1, -1);
        plan[20] = 0; plan[63] = 0;
        run_block(1'b0, 10, -1, -1);
        run_block(1'b0, 0, 40, -1);
        run_block(1'b0, 0, -1, -1);
        run_block(1'b0, 3, 64, -1);
        run_block(1'b1, 0, -1, 10);
        run_block(1'b0, 0, -1, -1);

        for (int i = 0; i < 24; i++) begin
            foreach (plan[r]) plan[r] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_block((i == 0) || ($urandom_range(0, 15) == 0), $urandom_range(0, 4), -1, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
